// File: rtl/mc_main_control.sv
// Main control FSM of the 16-bit multi-cycle processor.
// It steps each instruction through fetch, decode, execute, memory and write-back.
// It drives every datapath enable and mux select, plus the coarse alu_op class.
// Outputs are combinational from the state register.
// FETCH gates its load enables on mem_ready, and MEM_WR gates its done pulse on it.
// DECODE flags an illegal opcode in the same cycle it sees it.
module mc_main_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_JMP   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ANDI  = 4'b0110;
    localparam logic [3:0] OP_ORI   = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_RTYP = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_OR   = 3'b111;

    state_t state_reg;
    state_t state_next;
    logic   mem_ok;

    // Effective memory handshake: with waiting disabled every access completes at once.
    generate
        if (MEM_WAIT_EN) begin : g_mem_wait
            assign mem_ok = mem_ready;
        end else begin : g_no_mem_wait
            assign mem_ok = 1'b1;
        end
    endgenerate

    // State register; reset returns to FETCH and abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Debug view of the state; it is forced to FETCH while reset is held.
    assign state = rst ? 4'd0 : state_reg;

    // Next-state and datapath control decode; every output is quiet during reset.
    always_comb begin
        state_next    = state_reg;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    // Read the instruction at PC and compute PC+1 at the same time.
                    // Loads happen only once memory delivers the data.
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ok;
                    pc_write  = mem_ok;
                    if (mem_ok) begin
                        state_next = S_DECODE;
                    end
                end

                S_DECODE: begin
                    // Precompute the branch target into ALUOut while decoding.
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_LW, OP_SW:              state_next = S_MEM_ADDR;
                        OP_RTYPE:                  state_next = S_R_EXEC;
                        OP_BEQ:                    state_next = S_BRANCH;
                        OP_JMP:                    state_next = S_JUMP;
                        OP_ADDI, OP_ANDI, OP_ORI:  state_next = S_I_EXEC;
                        OP_HALT:                   state_next = S_HALT;
                        default: begin
                            state_next = S_FETCH;
                            illegal_op = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end

                S_MEM_ADDR: begin
                    // Effective address = register A + sign-extended immediate.
                    alu_src_a  = 1'b1;
                    alu_src_b  = 2'b10;
                    state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end

                S_MEM_RD: begin
                    // The read request stays asserted for the whole stall.
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ok) begin
                        state_next = S_MEM_WB;
                    end
                end

                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end

                S_MEM_WR: begin
                    // The write request stays asserted for the whole stall.
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ok;
                    if (mem_ok) begin
                        state_next = S_FETCH;
                    end
                end

                S_R_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_op     = ALU_RTYP;
                    state_next = S_R_WB;
                end

                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end

                S_BRANCH: begin
                    // Compare A and B; on zero, load the target that DECODE left in ALUOut.
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    instr_done    = 1'b1;
                    state_next    = S_FETCH;
                end

                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end

                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    case (opcode)
                        OP_ANDI: alu_op = ALU_AND;
                        OP_ORI:  alu_op = ALU_OR;
                        default: alu_op = ALU_ADD;
                    endcase
                    state_next = S_I_WB;
                end

                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end

                S_HALT: begin
                    // Parked with every output low until reset.
                    state_next = S_HALT;
                end

                default: begin
                    // Codes 13-15 cannot be reached normally; recover to FETCH.
                    state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control.
// A path-list reference model predicts the state and output vector every cycle.
// A latency check compares each instruction length against base count plus stalls.
// A directed walk pins literal expectations; random traffic with occasional resets follows.
module tb_mc_main_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd1;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0] pc_source, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    mc_main_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .instr_done(instr_done), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    logic [18:0] dut_vec;
    assign dut_vec = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                      ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                      alu_op, instr_done, illegal_op};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, expv, $time);
        end
    endtask

    function automatic bit legal(input logic [3:0] op);
        return (op <= 4'd7) || (op == 4'd15);
    endfunction

    // Total cycles of an instruction when memory never stalls.
    function automatic int base_cycles(input logic [3:0] op);
        case (op)
            4'd1:             return 5;
            4'd2:             return 4;
            4'd0:             return 4;
            4'd5, 4'd6, 4'd7: return 4;
            4'd3, 4'd4:       return 3;
            default:          return 2;
        endcase
    endfunction

    // Output vector required in a given step of an instruction.
    function automatic logic [18:0] exp_vec(input int st, input logic [3:0] op,
                                            input logic rdy, input logic r);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, asa = 0, dn = 0, ill = 0;
        logic [1:0] ps = 0, asb = 0;
        logic [2:0] ao = 0;
        if (!r) begin
            case (st)
                0:  begin mr = 1; asb = 2'd1; pw = rdy; irw = rdy; end
                1:  begin asb = 2'd3; if (!legal(op)) begin ill = 1; dn = 1; end end
                2:  begin asa = 1; asb = 2'd2; end
                3:  begin mr = 1; iod = 1; end
                4:  begin rw = 1; m2r = 1; dn = 1; end
                5:  begin mw = 1; iod = 1; dn = rdy; end
                6:  begin asa = 1; ao = 3'd3; end
                7:  begin rw = 1; rd = 1; dn = 1; end
                8:  begin asa = 1; ao = 3'd1; pwc = 1; ps = 2'd1; dn = 1; end
                9:  begin pw = 1; ps = 2'd2; dn = 1; end
                10: begin asa = 1; asb = 2'd2;
                          ao = (op == 4'd6) ? 3'd6 : (op == 4'd7) ? 3'd7 : 3'd0; end
                11: begin rw = 1; dn = 1; end
                default: ;
            endcase
        end
        return {pw, pwc, ps, iod, mr, mw, irw, m2r, rd, rw, asa, asb, ao, dn, ill};
    endfunction

    // Reference model: current step plus the queue of steps left in the instruction.
    int m_state = 0;
    int path[$];

    // Advance the model on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            path.delete();
        end else if (m_state == 0) begin
            if (mem_ready) m_state = 1;
        end else if (m_state == 1) begin
            path.delete();
            case (opcode)
                4'd0:             path = {6, 7};
                4'd1:             path = {2, 3, 4};
                4'd2:             path = {2, 5};
                4'd3:             path = {8};
                4'd4:             path = {9};
                4'd5, 4'd6, 4'd7: path = {10, 11};
                4'd15:            path = {12};
                default:          ;
            endcase
            m_state = (path.size() > 0) ? path.pop_front() : 0;
        end else if (m_state == 12) begin
            m_state = 12;
        end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
            m_state = m_state;
        end else begin
            m_state = (path.size() > 0) ? path.pop_front() : 0;
        end
    end

    int lat = 0;
    int stl = 0;

    // Compare the DUT with the model every cycle, and check instruction length.
    always @(negedge clk) begin
        chk("state", {28'd0, state}, rst ? 32'd0 : m_state);
        chk("outputs", {13'd0, dut_vec}, {13'd0, exp_vec(m_state, opcode, mem_ready, rst)});
        if (rst) begin
            lat = 0;
            stl = 0;
        end else begin
            lat++;
            if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) stl++;
            if (instr_done === 1'b1) begin
                chk("latency", lat, base_cycles(opcode) + stl);
                lat = 0;
                stl = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    int dones;

    initial begin
        // Reset held for three cycles: everything quiet.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_state", state, 0);
            chk("rst_outs", dut_vec, 0);
        end
        rst = 1'b0;
        #1;
        chk("fetch_state", state, 0);
        chk("fetch_rd_pw_ir", {mem_read, pc_write, ir_write}, 3'b111);

        // LW with memory always ready: 0,1,2,3,4,0.
        dones = 0;
        begin
            int lw_seq[5] = '{1, 2, 3, 4, 0};
            for (int i = 0; i < 5; i++) begin
                cyc();
                chk("lw_state", state, lw_seq[i]);
                if (instr_done) dones++;
                if (lw_seq[i] == 4) chk("lw_wb", {reg_write, mem_to_reg}, 2'b11);
            end
        end
        chk("lw_done_once", dones, 1);

        // R-type.
        opcode = 4'd0;
        cyc(); cyc();
        chk("r_exec", {state, alu_op, alu_src_b}, {4'd6, 3'b011, 2'b00});
        cyc();
        chk("r_wb", {state, reg_dst, reg_write}, {4'd7, 2'b11});
        cyc();

        // ORI.
        opcode = 4'd7;
        cyc(); cyc();
        chk("ori_exec", {state, alu_op, alu_src_b}, {4'd10, 3'b111, 2'b10});
        cyc(); cyc();

        // FETCH stalled for three cycles.
        opcode = 4'd2;
        mem_ready = 1'b0;
        #1;
        chk("fstall", {state, pc_write, ir_write, mem_read}, {4'd0, 3'b001});
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("fstall", {state, pc_write, ir_write, mem_read}, {4'd0, 3'b001});
        end
        mem_ready = 1'b1;
        #1;
        chk("fetch_go", {pc_write, ir_write}, 2'b11);

        // SW with MEM_WR stalled three cycles: mem_write high for four.
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        #1;
        chk("sw_wr", {state, mem_write, instr_done}, {4'd5, 2'b10});
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("sw_wr", {state, mem_write, instr_done}, {4'd5, 2'b10});
        end
        cyc();
        mem_ready = 1'b1;
        #1;
        chk("sw_wr_last", {state, mem_write, instr_done}, {4'd5, 2'b11});
        cyc();
        chk("sw_back", state, 0);

        // Illegal opcode 1010.
        opcode = 4'b1010;
        cyc();
        chk("ill_dec", {state, illegal_op, instr_done, reg_write, mem_write},
            {4'd1, 4'b1100});
        cyc();
        chk("ill_back", {state, reg_write, mem_write}, {4'd0, 2'b00});

        // HALT ignores opcode changes.
        opcode = 4'd15;
        cyc(); cyc();
        for (int i = 0; i < 10; i++) begin
            opcode = 4'($urandom);
            #1;
            chk("halt_state", state, 12);
            chk("halt_outs", dut_vec, 0);
            cyc();
        end

        // Reset during a MEM_RD stall.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        opcode = 4'd1;
        cyc(); cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        chk("rd_stall", {state, reg_write, mem_read}, {4'd3, 2'b01});
        rst = 1'b1;
        #1;
        chk("rd_rst_outs", dut_vec, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rd_rst_state", {state, reg_write}, {4'd0, 1'b0});

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 99) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            if (m_state == 0 || m_state == 12) opcode = 4'($urandom);
        end
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Main control state machine for the 16-bit multi-cycle processor. Sequences each instruction through fetch, decode, execute, memory and write-back cycles.
- Drives every datapath enable and mux select, plus the 3-bit alu_op that the ALU control decoder combines with the instruction function field.
- Sits directly upstream of the ALU control decoder. Consumes the instruction-register opcode and a memory-ready handshake.

Parameters:
- MEM_WAIT_EN, 1: 1 = FETCH/MEM_RD/MEM_WR stall until mem_ready; 0 = mem_ready ignored (treated as 1).

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  4  instruction register bits [15:12]; stable from DECODE until the next FETCH
- mem_ready  in  1  memory access completes this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero flag set
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  write-back data: 0 ALUOut, 1 memory data register
- reg_dst  out  1  destination register: 0 rt field, 1 rd field
- reg_write  out  1  register file write
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 register B, 01 constant 1, 10 sign-extended immediate, 11 branch offset
- alu_op  out  3  to ALU control decoder
- state  out  4  current state (debug)
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- alu_op encodings:
  - 000: add (PC increment, address and target computation)
  - 001: subtract (branch compare)
  - 011: R-type; function field selects the operation
  - 110: AND-immediate class
  - 111: OR-immediate class
- Opcode map: 0000 R-type, 0001 LW, 0010 SW, 0011 BEQ, 0100 JMP, 0101 ADDI, 0110 ANDI, 0111 ORI, 1111 HALT, all others illegal.
- State codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, HALT 12. Codes 13-15 are unreachable and go to FETCH.
- Any output not listed for a state is 0.
- Reset: while rst=1, every output is 0 and state=0; the first cycle after release is FETCH. Reset in any state, including mid-stall, abandons the instruction with no write enable asserted.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000.
  - ir_write and pc_write = mem_ready (Mealy gating).
  - mem_ready=1 -> DECODE; otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next state by opcode:
  - LW/SW -> MEM_ADDR
  - R-type -> R_EXEC
  - BEQ -> BRANCH
  - JMP -> JUMP
  - ADDI/ANDI/ORI -> I_EXEC
  - HALT -> HALT
  - illegal -> FETCH with illegal_op=1 and instr_done=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Stall until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1. -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Stall until mem_ready. instr_done=mem_ready; -> FETCH on mem_ready.
  - mem_write stays high for the whole stall.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=011. -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, instr_done=1. -> FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. -> FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. alu_op is 000 for ADDI, 110 for ANDI, 111 for ORI. -> I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. -> FETCH.
- HALT: all outputs 0. Held until rst; opcode changes are ignored.
- Cycle counts with mem_ready always 1: LW 5, SW 4, R-type 4, immediate ops 4, BEQ 3, JMP 3, illegal 2.
- Each additional stalled cycle adds 1 to the count.
- Stalled states never assert pc_write, ir_write or reg_write.
- In MEM_RD and MEM_WR, mem_read/mem_write stay asserted through the stall.

Test Plan:
- rst held 3 cycles, then released with mem_ready=1 -> during reset all outputs 0 and state=0; first cycle after release is FETCH with mem_read=1, pc_write=1, ir_write=1.
- LW (opcode 0001), mem_ready=1 -> states 0,1,2,3,4,0. MEM_WB shows reg_write=1, mem_to_reg=1; instr_done pulses exactly once.
- R-type (0000) -> R_EXEC shows alu_op=011, alu_src_b=00; R_WB shows reg_dst=1, reg_write=1. ORI (0111) -> I_EXEC shows alu_op=111, alu_src_b=10.
- FETCH and MEM_WR with mem_ready low for 3 cycles -> state holds and pc_write/ir_write stay 0 during FETCH stall; mem_write stays 1 for 4 cycles in MEM_WR; advances only when mem_ready=1.
- Opcode 1010 -> DECODE pulses illegal_op=1 and instr_done=1, then FETCH; no reg_write or mem_write at any point.
- Opcode 1111 -> HALT with all outputs 0 for 10 cycles despite opcode changes. Reset applied mid-MEM_RD stall -> state 0 next cycle, no reg_write.
